load_store_unit: RTL and testbench

//  Memory-access stage between the CPU datapath and dataMem. Accepts one load/store request at a time.

---
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response bus between the CPU datapath and the load/store unit.
// The master side issues requests and the slave side (the unit) answers them.
interface load_store_unit_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              reqValid;
    logic              reqReady;
    logic              reqWrite;
    logic [1:0]        reqSize;
    logic              reqSigned;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqData;
    logic              respValid;
    logic              respError;
    logic [DATA_W-1:0] respData;

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData,
        input  reqReady, respValid, respError, respData
    );

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData,
        output reqReady, respValid, respError, respData
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one request at a time, byte/half/word loads with extension,
// sub-word stores done as read-modify-write against a combinational-read dataMem.
module load_store_unit #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    load_store_unit_if.slave    bus,
    output logic [ADDR_W-3:0]   memAddress,
    output logic [DATA_W-1:0]   memDataOut,
    output logic                memWriteEnable,
    input  logic [DATA_W-1:0]   memDataIn
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} lsuState;

    lsuState           stateReg, stateNext;
    logic [1:0]        sizeReg, sizeNext;
    logic              signedReg, signedNext;
    logic [1:0]        laneReg, laneNext;
    logic [DATA_W-1:0] storeDataReg, storeDataNext;
    logic [ADDR_W-3:0] memAddressNext;
    logic [DATA_W-1:0] memDataOutNext;
    logic              memWriteEnableNext;
    logic              respValidReg, respValidNext;
    logic              respErrorReg, respErrorNext;
    logic [DATA_W-1:0] respDataReg, respDataNext;

    logic              reqError;
    logic [4:0]        laneShift;
    logic [DATA_W-1:0] laneWord;
    logic [DATA_W-1:0] laneMask;
    logic [DATA_W-1:0] mergedWord;
    logic [DATA_W-1:0] loadResult;

    assign bus.reqReady  = (stateReg == IDLE);
    assign bus.respValid = respValidReg;
    assign bus.respError = respErrorReg;
    assign bus.respData  = respDataReg;

    assign reqError = (bus.reqSize == 2'd3)
                    | ((bus.reqSize == 2'd1) & bus.reqAddr[0])
                    | ((bus.reqSize == 2'd2) & (|bus.reqAddr[1:0]));

    // Lane arithmetic uses the captured request, memDataIn is the word at memAddress.
    assign laneShift  = {laneReg, 3'b000};
    assign laneWord   = memDataIn >> laneShift;
    assign laneMask   = ((sizeReg == 2'd0) ? {{(DATA_W-8){1'b0}}, 8'hFF}
                                           : {{(DATA_W-16){1'b0}}, 16'hFFFF}) << laneShift;
    assign mergedWord = (memDataIn & ~laneMask) | ((storeDataReg << laneShift) & laneMask);

    always_comb begin
        loadResult = laneWord;
        case (sizeReg)
            2'd0:    loadResult = {{(DATA_W-8){signedReg & laneWord[7]}}, laneWord[7:0]};
            2'd1:    loadResult = {{(DATA_W-16){signedReg & laneWord[15]}}, laneWord[15:0]};
            default: loadResult = laneWord;
        endcase
    end

    always_comb begin
        stateNext          = stateReg;
        sizeNext           = sizeReg;
        signedNext         = signedReg;
        laneNext           = laneReg;
        storeDataNext      = storeDataReg;
        memAddressNext     = memAddress;
        memDataOutNext     = memDataOut;
        memWriteEnableNext = memWriteEnable;
        respValidNext      = 1'b0;
        respErrorNext      = 1'b0;
        respDataNext       = '0;
        case (stateReg)
            IDLE: begin
                if (bus.reqValid) begin
                    sizeNext      = bus.reqSize;
                    signedNext    = bus.reqSigned;
                    laneNext      = bus.reqAddr[1:0];
                    storeDataNext = bus.reqData;
                    if (reqError) begin
                        // Rejected requests never touch the memory side.
                        respValidNext = 1'b1;
                        respErrorNext = 1'b1;
                        stateNext     = DONE;
                    end else begin
                        memAddressNext = bus.reqAddr[ADDR_W-1:2];
                        if (!bus.reqWrite) begin
                            memWriteEnableNext = 1'b0;
                            stateNext          = LOAD;
                        end else if (bus.reqSize == 2'd2) begin
                            memDataOutNext     = bus.reqData;
                            memWriteEnableNext = 1'b1;
                            stateNext          = WRITE;
                        end else begin
                            memWriteEnableNext = 1'b0;
                            stateNext          = RMW_RD;
                        end
                    end
                end
            end
            LOAD: begin
                respDataNext  = loadResult;
                respValidNext = 1'b1;
                stateNext     = DONE;
            end
            RMW_RD: begin
                memDataOutNext     = mergedWord;
                memWriteEnableNext = 1'b1;
                stateNext          = WRITE;
            end
            WRITE: begin
                memWriteEnableNext = 1'b0;
                respValidNext      = 1'b1;
                stateNext          = DONE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg       <= IDLE;
            sizeReg        <= 2'd0;
            signedReg      <= 1'b0;
            laneReg        <= 2'd0;
            storeDataReg   <= '0;
            memAddress     <= '0;
            memDataOut     <= '0;
            memWriteEnable <= 1'b0;
            respValidReg   <= 1'b0;
            respErrorReg   <= 1'b0;
            respDataReg    <= '0;
        end else begin
            stateReg       <= stateNext;
            sizeReg        <= sizeNext;
            signedReg      <= signedNext;
            laneReg        <= laneNext;
            storeDataReg   <= storeDataNext;
            memAddress     <= memAddressNext;
            memDataOut     <= memDataOutNext;
            memWriteEnable <= memWriteEnableNext;
            respValidReg   <= respValidNext;
            respErrorReg   <= respErrorNext;
            respDataReg    <= respDataNext;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic checked against
// a byte-addressed reference memory, with a word-wide dataMem model attached to the DUT.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(24), .DATA_W(32)) bus();

    logic [21:0] memAddress;
    logic [31:0] memDataOut;
    logic [31:0] memDataIn;
    logic        memWriteEnable;

    logic [31:0] benchMem [0:1023];
    logic [7:0]  refBytes [0:4095];

    int errors = 0;
    int checks = 0;

    assign memDataIn = benchMem[memAddress[9:0]];
    always @(posedge clk) begin
        if (memWriteEnable) benchMem[memAddress[9:0]] <= memDataOut;
    end

    load_store_unit #(.ADDR_W(24), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .memAddress     (memAddress),
        .memDataOut     (memDataOut),
        .memWriteEnable (memWriteEnable),
        .memDataIn      (memDataIn)
    );

    function automatic int sizeBytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] refWord(input logic [23:0] a);
        int base = int'(a[11:2]) * 4;
        return {refBytes[base+3], refBytes[base+2], refBytes[base+1], refBytes[base]};
    endfunction

    // Loads assembled byte by byte, sign extension done by subtracting 2^(8n).
    function automatic logic [31:0] refLoad(input logic [1:0] sz, input logic sg, input logic [23:0] a);
        int nb = sizeBytes(sz);
        int base = int'(a[11:0]);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < nb; i++) v = v + (32'(refBytes[base+i]) << (8*i));
        if (sg && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8*nb));
        return v;
    endfunction

    task automatic refStore(input logic [1:0] sz, input logic [23:0] a, input logic [31:0] d);
        int nb = sizeBytes(sz);
        int base = int'(a[11:0]);
        for (int i = 0; i < nb; i++) refBytes[base+i] = d[8*i +: 8];
    endtask

    task automatic runTxn(input string name, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [23:0] a, input logic [31:0] d, output logic [31:0] got);
        logic        err;
        logic        gotErr;
        logic [31:0] expData;
        logic [31:0] wdata;
        int          expLat;
        int          lat;
        int          we;
        err     = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        expLat  = err ? 1 : (w && sz != 2'd2) ? 3 : 2;
        expData = (err || w) ? 32'd0 : refLoad(sz, sg, a);
        lat = 0; we = 0; got = 'x; gotErr = 1'bx; wdata = 'x;
        @(negedge clk);
        checks++;
        if (bus.reqReady !== 1'b1) begin errors++; $display("FAIL %s ready_before: got %b expected 1", name, bus.reqReady); end
        bus.reqWrite = w; bus.reqSize = sz; bus.reqSigned = sg; bus.reqAddr = a; bus.reqData = d;
        bus.reqValid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.reqValid = 1'b0;
                if (!err) begin
                    checks++;
                    if (memAddress !== a[23:2]) begin errors++; $display("FAIL %s mem_address: got %h expected %h", name, memAddress, a[23:2]); end
                end
            end
            if (memWriteEnable === 1'b1) begin
                we++;
                wdata = memDataOut;
                checks++;
                if (memAddress !== a[23:2]) begin errors++; $display("FAIL %s write_address: got %h expected %h", name, memAddress, a[23:2]); end
            end
            if (bus.respValid === 1'b1) begin
                lat = k; got = bus.respData; gotErr = bus.respError;
                break;
            end
            checks++;
            if (bus.reqReady !== 1'b0) begin errors++; $display("FAIL %s ready_busy: got %b expected 0 at cycle %0d", name, bus.reqReady, k); end
        end
        if (w && !err) refStore(sz, a, d);
        checks++;
        if (lat != expLat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, expLat); end
        checks++;
        if (gotErr !== err) begin errors++; $display("FAIL %s resp_error: got %b expected %b", name, gotErr, err); end
        checks++;
        if (got !== expData) begin errors++; $display("FAIL %s resp_data: got %h expected %h", name, got, expData); end
        checks++;
        if (we != ((w && !err) ? 1 : 0)) begin errors++; $display("FAIL %s write_pulses: got %0d expected %0d", name, we, (w && !err) ? 1 : 0); end
        if (w && !err) begin
            checks++;
            if (wdata !== refWord(a)) begin errors++; $display("FAIL %s write_data: got %h expected %h", name, wdata, refWord(a)); end
        end
        @(negedge clk);
        checks++;
        if (bus.respValid !== 1'b0 || bus.reqReady !== 1'b1) begin
            errors++; $display("FAIL %s after_resp: got valid=%b ready=%b expected valid=0 ready=1", name, bus.respValid, bus.reqReady);
        end
        $display("txn %s: write=%0d size=%0d signed=%0d addr=%h data=%h -> latency=%0d error=%b resp=%h", name, w, sz, sg, a, d, lat, gotErr, got);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.reqValid = 1'b1; bus.reqWrite = 1'b1; bus.reqSize = 2'd2; bus.reqSigned = 1'b0;
        bus.reqAddr = 24'h000010; bus.reqData = 32'h12345678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (memAddress !== 22'd0 || memDataOut !== 32'd0 || memWriteEnable !== 1'b0) begin
            errors++; $display("FAIL reset_mem: got addr=%h data=%h we=%b expected all zero", memAddress, memDataOut, memWriteEnable);
        end
        checks++;
        if (bus.respValid !== 1'b0 || bus.respError !== 1'b0 || bus.respData !== 32'd0) begin
            errors++; $display("FAIL reset_resp: got valid=%b err=%b data=%h expected all zero", bus.respValid, bus.respError, bus.respData);
        end
        checks++;
        if (bus.reqReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.reqReady); end
        checks++;
        if (benchMem[4] !== refWord(24'h10)) begin errors++; $display("FAIL reset_no_write: got %h expected %h", benchMem[4], refWord(24'h10)); end
        bus.reqValid = 1'b0;
        reset = 1'b1;
        $display("txn reset: outputs idle, request ignored");
    endtask

    task automatic test_word_store();
        logic [31:0] got;
        runTxn("word_store", 1'b1, 2'd2, 1'b0, 24'h000010, 32'hDEADBEEF, got);
        checks++;
        if (benchMem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_store_mem: got %h expected deadbeef", benchMem[4]); end
    endtask

    task automatic test_byte_store();
        logic [31:0] got;
        runTxn("byte_store", 1'b1, 2'd0, 1'b0, 24'h000011, 32'hFFFFFF5A, got);
        checks++;
        if (benchMem[4] !== 32'hDEAD5AEF) begin errors++; $display("FAIL byte_store_mem: got %h expected dead5aef", benchMem[4]); end
    endtask

    task automatic test_loads();
        logic [31:0] got;
        runTxn("load_b_s", 1'b0, 2'd0, 1'b1, 24'h000013, 32'd0, got);
        checks++;
        if (got !== 32'hFFFFFFDE) begin errors++; $display("FAIL load_b_s_const: got %h expected ffffffde", got); end
        runTxn("load_b_u", 1'b0, 2'd0, 1'b0, 24'h000013, 32'd0, got);
        checks++;
        if (got !== 32'h000000DE) begin errors++; $display("FAIL load_b_u_const: got %h expected 000000de", got); end
        runTxn("load_h_s", 1'b0, 2'd1, 1'b1, 24'h000012, 32'd0, got);
        checks++;
        if (got !== 32'hFFFFDEAD) begin errors++; $display("FAIL load_h_s_const: got %h expected ffffdead", got); end
    endtask

    task automatic test_errors();
        logic [31:0] got;
        runTxn("err_half", 1'b1, 2'd1, 1'b0, 24'h000011, 32'h0000AAAA, got);
        runTxn("err_word", 1'b0, 2'd2, 1'b1, 24'h000012, 32'd0, got);
        runTxn("err_size3", 1'b1, 2'd3, 1'b0, 24'h000010, 32'h11111111, got);
        checks++;
        if (benchMem[4] !== 32'hDEAD5AEF) begin errors++; $display("FAIL errors_mem: got %h expected dead5aef", benchMem[4]); end
    endtask

    task automatic test_reset_mid_rmw();
        @(negedge clk);
        bus.reqWrite = 1'b1; bus.reqSize = 2'd0; bus.reqSigned = 1'b0;
        bus.reqAddr = 24'h000012; bus.reqData = 32'h00000077;
        bus.reqValid = 1'b1;
        @(negedge clk);
        bus.reqValid = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (memWriteEnable !== 1'b0 || bus.respValid !== 1'b0) begin
                errors++; $display("FAIL rmw_reset_quiet: got we=%b valid=%b expected 0 0", memWriteEnable, bus.respValid);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.reqReady !== 1'b1) begin errors++; $display("FAIL rmw_reset_ready: got %b expected 1", bus.reqReady); end
        checks++;
        if (benchMem[4] !== 32'hDEAD5AEF) begin errors++; $display("FAIL rmw_reset_mem: got %h expected dead5aef", benchMem[4]); end
        $display("txn reset_mid_rmw: byte store to 000012 aborted, word=%h", benchMem[4]);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sizes [3];
        logic [23:0] addrs [3];
        logic [31:0] expQ [$];
        int issued = 0;
        int seen = 0;
        sizes = '{2'd0, 2'd1, 2'd2};
        addrs = '{24'h000013, 24'h000012, 24'h000010};
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.respValid === 1'b1) begin
                seen++;
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_resp: got %h expected none", bus.respData);
                end else begin
                    logic [31:0] e;
                    e = expQ.pop_front();
                    if (bus.respData !== e || bus.respError !== 1'b0) begin
                        errors++; $display("FAIL b2b_resp: got %h err=%b expected %h err=0", bus.respData, bus.respError, e);
                    end
                end
                checks++;
                if (bus.reqReady !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy: got %b expected 0", bus.reqReady); end
                $display("txn b2b_load %0d: resp=%h", seen, bus.respData);
            end
            if (bus.reqReady === 1'b1) begin
                if (issued < 3) begin
                    bus.reqWrite = 1'b0; bus.reqSize = sizes[issued]; bus.reqSigned = 1'b1;
                    bus.reqAddr = addrs[issued]; bus.reqData = 32'd0;
                    bus.reqValid = 1'b1;
                    expQ.push_back(refLoad(sizes[issued], 1'b1, addrs[issued]));
                    issued++;
                end else begin
                    bus.reqValid = 1'b0;
                end
            end
            if (issued == 3 && expQ.size() == 0 && bus.reqValid == 1'b0) break;
        end
        bus.reqValid = 1'b0;
        checks++;
        if (seen != 3 || expQ.size() != 0) begin
            errors++; $display("FAIL b2b_count: got %0d responses expected 3", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        for (int n = 0; n < 60; n++) begin
            logic        w;
            logic [1:0]  sz;
            logic [23:0] a;
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 24'($urandom);
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~24'(sizeBytes(sz) - 1);
            runTxn("random", w, sz, 1'($urandom_range(0, 1)), a, $urandom, got);
        end
    endtask

    task automatic test_mem_sweep();
        int bad = 0;
        for (int i = 0; i < 1024; i++) begin
            checks++;
            if (benchMem[i] !== refWord(24'(i * 4))) begin
                errors++; bad++;
                if (bad <= 8) $display("FAIL mem_sweep word %0d: got %h expected %h", i, benchMem[i], refWord(24'(i * 4)));
            end
        end
        $display("txn mem_sweep: 1024 words compared");
    endtask

    initial begin
        bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqSize = 2'd0; bus.reqSigned = 1'b0;
        bus.reqAddr = '0; bus.reqData = '0;
        for (int i = 0; i < 4096; i++) refBytes[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) benchMem[i] = refWord(24'(i * 4));
        test_reset();
        test_word_store();
        test_byte_store();
        test_loads();
        test_errors();
        test_reset_mid_rmw();
        test_back_to_back();
        test_random();
        test_mem_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
